// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline stage registers.
package pipe_pkg;

    // Occupancy view of a stage; the encoding mirrors {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } stage_state_e;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic        reg_write;
        logic [1:0]  result_src;
        logic [4:0]  rd;
    } mem_wb_payload_t;

    localparam int MEM_WB_PAYLOAD_W = $bits(mem_wb_payload_t);

    // Map the two valid bits onto a stage state. The orphan-skid pattern
    // cannot be reached and is treated as EMPTY.
    function automatic stage_state_e state_of(input logic main_valid, input logic skid_valid);
        stage_state_e s;
        if (main_valid && skid_valid)
            s = FULL;
        else if (main_valid)
            s = ONE;
        else
            s = EMPTY;
        return s;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// ready_o depends on registered state only, so no combinational path runs
// from ready_i back upstream.
//
//   state | meaning
//   EMPTY | nothing held, main and skid empty
//   ONE   | main holds the head payload, skid empty
//   FULL  | main holds the head, skid holds the next payload; ready_o low
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W      = MEM_WB_PAYLOAD_W,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [PAYLOAD_W-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [PAYLOAD_W-1:0] data_o,
    output logic [1:0]           count_o
);

    logic                 main_valid, skid_valid;
    logic [PAYLOAD_W-1:0] main_data, skid_data;

    logic                 main_valid_n, skid_valid_n;
    logic [PAYLOAD_W-1:0] main_data_n, skid_data_n;

    stage_state_e state;
    logic         in_fire, out_fire;

    assign ready_o  = ~skid_valid;
    assign valid_o  = main_valid;
    assign data_o   = main_data;
    assign count_o  = {1'b0, main_valid} + {1'b0, skid_valid};
    assign in_fire  = valid_i & ready_o;
    assign out_fire = main_valid & ready_i;
    assign state    = state_of(main_valid, skid_valid);

    // Next-state and data-load selection; flush overrides every fire.
    always_comb begin
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        main_data_n  = main_data;
        skid_data_n  = skid_data;

        case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_data_n  = data_i;
                    main_valid_n = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_n = data_i;
                end else if (in_fire) begin
                    skid_data_n  = data_i;
                    skid_valid_n = 1'b1;
                end else if (out_fire) begin
                    main_valid_n = 1'b0;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_data_n  = skid_data;
                    skid_valid_n = 1'b0;
                end
            end
            default: begin
                main_valid_n = 1'b0;
                skid_valid_n = 1'b0;
            end
        endcase

        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                main_data_n = '0;
                skid_data_n = '0;
            end else begin
                main_data_n = main_data;
                skid_data_n = skid_data;
            end
        end
    end

    // Stage storage; reset discards both entries and zeroes the payloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            main_data  <= main_data_n;
            skid_data  <= skid_data_n;
        end
    end

`ifndef SYNTHESIS
    a_no_orphan_skid: assert property (@(posedge clk) disable iff (!rst_n)
        !(skid_valid && !main_valid));
`endif

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Generic elastic pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Successor to the fixed-field stall/flush stage registers. Payload width is a parameter, and the stage holds full throughput while downstream back-pressures.
- Inserted between any two pipeline stages (IF/ID … MEM/WB). It is the first stage usable where a cache miss stalls only downstream.

Parameters:
- PAYLOAD_W, 104, width of the opaque payload (default = MEM/WB bundle: PCPlus4, ALUResult, ReadData, RegWrite, ResultSrc, Rd).
- CLEAR_ON_FLUSH, 1, 1 = zero both data registers on flush; 0 = data registers hold on flush (valids still cleared).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous active-high pipeline flush.
- valid_i  input  1  upstream payload valid.
- ready_o  output  1  stage can accept; equals NOT skid_valid (registered-state only, no combinational path from ready_i).
- data_i  input  PAYLOAD_W  upstream payload.
- valid_o  output  1  data_o valid.
- ready_i  input  1  downstream accepts.
- data_o  output  PAYLOAD_W  payload; driven directly from main register.
- count_o  output  2  occupancy 0..2.

Behaviour:
- Handshake terms: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Storage: main register {main_valid, main_data} and skid register {skid_valid, skid_data}. valid_o = main_valid.
- FSM states (encoded from the valids):
  - EMPTY: main_valid=0, skid_valid=0.
  - ONE: main_valid=1, skid_valid=0.
  - FULL: both valid.
- Transitions when flush=0:
  - EMPTY: in_fire -> main<=data_i, go to ONE; otherwise stay.
  - ONE, in_fire & out_fire -> main<=data_i, stay ONE.
  - ONE, in_fire & !out_fire -> skid<=data_i, go to FULL.
  - ONE, !in_fire & out_fire -> go to EMPTY (main_data holds).
  - ONE, neither -> hold.
  - FULL: ready_o=0, so in_fire is impossible. out_fire -> main<=skid_data, go to ONE; otherwise hold.
- Data registers load only on the fires above. Payload is never altered or reordered; strict FIFO order.
- Latency: 1 cycle from in_fire to valid_o in EMPTY. Sustained throughput is 1 transfer/cycle with ready_i=1.
- A stall (ready_i=0) with valid_o=1 holds data_o and valid_o stable until out_fire; this is an AXI-style hold rule.
- flush has priority over all fires in the same cycle:
  - Next state EMPTY; an incoming payload is dropped.
  - The out_fire in that cycle still counts as consumed downstream (downstream sees it).
  - CLEAR_ON_FLUSH=1 -> main_data and skid_data <= 0.
- Reset (rst_n=0, asynchronous):
  - valid_o=0, count_o=0, data_o=0, skid cleared, state EMPTY, so ready_o=1.
  - Reset mid-transfer discards both entries.
- count_o = main_valid + skid_valid.
- Illegal encoding (skid_valid=1, main_valid=0) is unreachable; assertion required.

Decomposition:
- Package pipe_pkg:
  - stage_state_e enum {EMPTY, ONE, FULL}.
  - mem_wb_payload_t packed struct (pc_plus4, alu_result, read_data, reg_write, result_src[1:0], rd[4:0]) with localparam MEM_WB_PAYLOAD_W = $bits(mem_wb_payload_t) = 104.
- No sub-module; single module with one always_ff (async reset) plus combinational next-state logic.

Test Plan:
- Reset then stream: rst_n low 2 cycles; then valid_i=1, ready_i=1, data_i=0x1,0x2,0x3 on consecutive cycles -> valid_o=1 one cycle after each, data_o=0x1,0x2,0x3 in order, count_o=1 throughout, ready_o=1 always.
- Back-pressure fill: ONE with data 0xA; ready_i=0, valid_i=1, data_i=0xB -> count_o=2, ready_o=0, data_o stays 0xA; raise ready_i -> data_o=0xA accepted, next cycle data_o=0xB, count_o=1, ready_o=1.
- Flush priority: FULL (0xA,0xB); flush=1 with ready_i=1 and valid_i=1, data_i=0xC -> next cycle valid_o=0, count_o=0, data_o=0 (CLEAR_ON_FLUSH=1), 0xC never appears.
- Drain to empty: ONE with 0x5; valid_i=0, ready_i=1 -> next cycle valid_o=0, count_o=0; data_o unchanged when CLEAR_ON_FLUSH is irrelevant (no flush).
- Async reset mid-operation: FULL, assert rst_n low between clock edges -> valid_o, count_o, data_o drop to 0 immediately and ready_o=1 without a clock edge.
- Randomised ready/valid over 1000 cycles with scoreboard -> no loss, duplication or reorder; ready_o never depends on ready_i in the same cycle.
